// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types, constants and helpers for the MIDI UART receiver
package midi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_t;

   localparam int MIDI_BAUD = 31250;

   // Rounded clocks per oversample tick.
   function automatic int calc_div(input int clk_hz, input int baud, input int os);
      return (clk_hz + (baud * os) / 2) / (baud * os);
   endfunction

   // Two-out-of-three vote used to decide each bit.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/midi_baud_tick.sv
// rtl/midi_baud_tick.sv - oversample tick generator, one pulse every DIV clocks
module midi_baud_tick #(
   parameter int DIV = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Down-counter reloaded on clear or at zero; the zero crossing emits the tick.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt  <= RELOAD;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt - 1'b1;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - 8N1 MIDI serial receiver with 16x oversampling and majority vote
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = MIDI_BAUD,
   parameter int OVERSAMPLE  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       framing_err,
   output logic       busy
);

   // OVERSAMPLE must be at least 8 so the three vote samples sit inside one bit.
   localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
   localparam int OSW = $clog2(OVERSAMPLE);
   localparam int MID = OVERSAMPLE / 2;
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
   localparam logic [OSW-1:0] S_LO    = OSW'(MID - 1);
   localparam logic [OSW-1:0] S_MID   = OSW'(MID);
   localparam logic [OSW-1:0] S_HI    = OSW'(MID + 1);

   uart_state_t    state;
   logic           rx_meta;
   logic           rx_s;
   logic           tick;
   logic           clear;
   logic [OSW-1:0] os_cnt;
   logic [OSW-1:0] os_next;
   logic [2:0]     bit_idx;
   logic [7:0]     shift_reg;
   logic           samp_lo;
   logic           samp_mid;
   logic           vote;

   // Tick phase restarts on every falling edge seen from IDLE.
   assign clear   = (state == IDLE);
   assign busy    = (state != IDLE);
   assign os_next = (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
   assign vote    = maj3(samp_lo, samp_mid, rx_s);

   midi_baud_tick #(
      .DIV(DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .tick (tick)
   );

   // Two-flop synchronizer, reset high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Capture the two early vote samples of each bit period.
   always_ff @(posedge clk) begin
      if (rst) begin
         samp_lo  <= 1'b1;
         samp_mid <= 1'b1;
      end else if (tick && state != IDLE && state != BREAK) begin
         if (os_next == S_LO)  samp_lo  <= rx_s;
         if (os_next == S_MID) samp_mid <= rx_s;
      end
   end

   // Frame state machine; decisions happen on the MID+1 tick, bit steps on the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         os_cnt      <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         byte_out    <= '0;
         byte_valid  <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         byte_valid  <= 1'b0;
         framing_err <= 1'b0;
         case (state)
            IDLE: begin
               os_cnt  <= '0;
               bit_idx <= '0;
               if (!rx_s) state <= START;
            end
            START: if (tick) begin
               os_cnt <= os_next;
               if (os_next == S_HI && vote) begin
                  state <= IDLE;
               end else if (os_next == '0) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end
            DATA: if (tick) begin
               os_cnt <= os_next;
               if (os_next == S_HI) shift_reg[bit_idx] <= vote;
               if (os_next == '0) begin
                  if (bit_idx == 3'd7) state   <= STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end
            end
            STOP: if (tick) begin
               os_cnt <= os_next;
               if (os_next == S_HI) begin
                  if (vote) begin
                     byte_out   <= shift_reg;
                     byte_valid <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     framing_err <= 1'b1;
                     os_cnt      <= '0;
                     state       <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (!rx_s) begin
                  os_cnt <= '0;
               end else if (tick) begin
                  if (os_cnt == OS_LAST) state  <= IDLE;
                  else                   os_cnt <= os_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - self-checking bench for midi_uart_rx with a wire-level reference model
module tb_midi_uart_rx;

   // Clock scaled down so the whole run stays short; timing expectations scale with it.
   localparam int CLK_HZ  = 5_000_000;
   localparam int BAUD    = 31250;
   localparam int OS      = 16;
   localparam int BIT     = CLK_HZ / BAUD;
   localparam int TICK    = BIT / OS;
   localparam int FRAME   = 10 * BIT;
   localparam int LATENCY = 9 * BIT + (OS / 2 + 1) * TICK + 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       framing_err;
   logic       busy;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   int unsigned vcyc_q[$];
   logic [7:0]  vdat_q[$];
   int          ferr_cnt = 0;
   bit          rule_bad = 1'b0;
   logic        pbv = 1'b0;
   logic        pfe = 1'b0;

   midi_uart_rx #(
      .CLK_FREQ_HZ(CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .framing_err(framing_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record output pulses and note any pulse-shape rule violation.
   always @(negedge clk) begin
      if (cyc > 2) begin
         if (byte_valid === 1'b1) begin
            vcyc_q.push_back(cyc);
            vdat_q.push_back(byte_out);
         end
         if (framing_err === 1'b1) ferr_cnt++;
         if ((byte_valid && framing_err) || (byte_valid && pbv) || (framing_err && pfe))
            rule_bad = 1'b1;
      end
      pbv = byte_valid;
      pfe = framing_err;
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic clear_log();
      vcyc_q.delete();
      vdat_q.delete();
      ferr_cnt = 0;
   endtask

   // Drives the line for n_cyc clocks of a 10-bit frame, optionally forcing a low glitch.
   task automatic drive_frame(input logic [7:0] data, input logic stop, input int g_start,
                              input int g_len, input int n_cyc, output int unsigned fall);
      logic [9:0] bits;
      bits = {stop, data, 1'b0};
      fall = cyc;
      for (int k = 0; k < n_cyc; k++) begin
         rx = bits[k / BIT];
         if (k >= g_start && k < g_start + g_len) rx = 1'b0;
         @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(4);
      checks++; if (byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte_out: got %h want 00", byte_out); end
      checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
      checks++; if (framing_err !== 1'b0) begin failures++; $display("FAIL reset_framing_err: got %b want 0", framing_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      idle(2 * BIT);
   endtask

   task automatic test_single();
      int unsigned fall;
      int          lat;
      clear_log();
      drive_frame(8'h90, 1'b1, 0, 0, FRAME, fall);
      for (int i = 0; i < 2 * BIT && vdat_q.size() == 0; i++) @(negedge clk);
      checks++;
      if (vdat_q.size() != 1) begin
         failures++; $display("FAIL single_count: got %0d want 1", vdat_q.size());
      end else begin
         checks++; if (vdat_q[0] !== 8'h90) begin failures++; $display("FAIL single_data: got %h want 90", vdat_q[0]); end
         lat = int'(vcyc_q[0]) - int'(fall);
         checks++;
         if (lat < LATENCY - TICK || lat > LATENCY + TICK) begin
            failures++; $display("FAIL single_latency: got %0d want %0d+-%0d", lat, LATENCY, TICK);
         end
      end
      checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  exp [3];
      int unsigned fall;
      int          gap;
      exp[0] = 8'h90; exp[1] = 8'h3C; exp[2] = 8'h64;
      clear_log();
      for (int i = 0; i < 3; i++) drive_frame(exp[i], 1'b1, 0, 0, FRAME, fall);
      idle(2 * BIT);
      checks++;
      if (vdat_q.size() != 3) begin
         failures++; $display("FAIL b2b_count: got %0d want 3", vdat_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (vdat_q[i] !== exp[i]) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", i, vdat_q[i], exp[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            gap = int'(vcyc_q[i]) - int'(vcyc_q[i-1]);
            checks++;
            if (gap < FRAME - TICK || gap > FRAME + TICK) begin
               failures++; $display("FAIL b2b_spacing%0d: got %0d want %0d+-%0d", i, gap, FRAME, TICK);
            end
         end
      end
      checks++; if (byte_out !== 8'h64) begin failures++; $display("FAIL b2b_hold: got %h want 64", byte_out); end
      checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
   endtask

   task automatic test_start_glitch();
      int waited;
      clear_log();
      rx = 1'b0;
      idle(5);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise: got %b want 1", busy); end
      idle(BIT * 30 / 160 - 5);
      rx = 1'b1;
      waited = 0;
      while (busy === 1'b1 && waited < 10 * TICK) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_fall: got %b want 0 within %0d clk", busy, 10 * TICK); end
      idle(2 * BIT);
      checks++; if (vdat_q.size() != 0) begin failures++; $display("FAIL glitch_valid: got %0d want 0", vdat_q.size()); end
      checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); end
   endtask

   task automatic test_framing();
      int unsigned fall;
      clear_log();
      drive_frame(8'h55, 1'b0, 0, 0, FRAME, fall);
      idle(5000);
      checks++; if (ferr_cnt != 1) begin failures++; $display("FAIL frame_ferr: got %0d want 1", ferr_cnt); end
      checks++; if (vdat_q.size() != 0) begin failures++; $display("FAIL frame_valid: got %0d want 0", vdat_q.size()); end
      checks++; if (byte_out !== 8'h64) begin failures++; $display("FAIL frame_hold: got %h want 64", byte_out); end
      drive_frame(8'h80, 1'b1, 0, 0, FRAME, fall);
      idle(BIT);
      checks++;
      if (vdat_q.size() != 1) begin
         failures++; $display("FAIL frame_next_count: got %0d want 1", vdat_q.size());
      end else begin
         checks++; if (vdat_q[0] !== 8'h80) begin failures++; $display("FAIL frame_next_data: got %h want 80", vdat_q[0]); end
      end
      checks++; if (ferr_cnt != 1) begin failures++; $display("FAIL frame_next_ferr: got %0d want 1", ferr_cnt); end
   endtask

   task automatic test_data_glitch();
      int unsigned fall;
      clear_log();
      drive_frame(8'hA5, 1'b1, BIT + (OS / 2) * TICK - TICK / 2, TICK, FRAME, fall);
      idle(BIT);
      checks++;
      if (vdat_q.size() != 1) begin
         failures++; $display("FAIL vote_count: got %0d want 1", vdat_q.size());
      end else begin
         checks++; if (vdat_q[0] !== 8'hA5) begin failures++; $display("FAIL vote_data: got %h want A5", vdat_q[0]); end
      end
      checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL vote_ferr: got %0d want 0", ferr_cnt); end
   endtask

   task automatic test_reset_midframe();
      int unsigned fall;
      clear_log();
      drive_frame(8'hF0, 1'b1, 0, 0, 5 * BIT + BIT / 2, fall);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (byte_out !== 8'h00) begin failures++; $display("FAIL rstmid_byte_out: got %h want 00", byte_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      idle(5 * BIT);
      checks++; if (vdat_q.size() != 0 || ferr_cnt != 0) begin failures++; $display("FAIL rstmid_pulse: got valid=%0d ferr=%0d want 0 0", vdat_q.size(), ferr_cnt); end
      drive_frame(8'h3C, 1'b1, 0, 0, FRAME, fall);
      idle(BIT);
      checks++;
      if (vdat_q.size() != 1) begin
         failures++; $display("FAIL rstmid_next_count: got %0d want 1", vdat_q.size());
      end else begin
         checks++; if (vdat_q[0] !== 8'h3C) begin failures++; $display("FAIL rstmid_next_data: got %h want 3C", vdat_q[0]); end
      end
      checks++; if (byte_out !== 8'h3C) begin failures++; $display("FAIL rstmid_hold: got %h want 3C", byte_out); end
   endtask

   // Random frames with random stop-bit errors and idle gaps against a queue model.
   task automatic test_random();
      logic [7:0]  exp_q[$];
      logic [7:0]  exp_last;
      logic [7:0]  data;
      logic        stop;
      int          exp_ferr;
      int          gap;
      bit          prev_bad;
      int unsigned fall;
      clear_log();
      exp_last = 8'h3C;
      exp_ferr = 0;
      prev_bad = 1'b0;
      for (int i = 0; i < 14; i++) begin
         data = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         gap  = prev_bad ? 2 * BIT : int'($urandom_range(0, BIT / 2));
         idle(gap);
         drive_frame(data, stop, 0, 0, FRAME, fall);
         if (stop) begin
            exp_q.push_back(data);
            exp_last = data;
         end else begin
            exp_ferr++;
         end
         prev_bad = !stop;
      end
      idle(3 * BIT);
      checks++;
      if (vdat_q.size() != exp_q.size()) begin
         failures++; $display("FAIL rand_count: got %0d want %0d", vdat_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (vdat_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_data%0d: got %h want %h", i, vdat_q[i], exp_q[i]); end
         end
      end
      checks++; if (ferr_cnt != exp_ferr) begin failures++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt, exp_ferr); end
      checks++; if (byte_out !== exp_last) begin failures++; $display("FAIL rand_hold: got %h want %h", byte_out, exp_last); end
   endtask

   task automatic test_pulse_rules();
      checks++; if (rule_bad !== 1'b0) begin failures++; $display("FAIL pulse_rules: got violation=%b want 0", rule_bad); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_start_glitch();
      test_framing();
      test_data_glitch();
      test_reset_midframe();
      test_random();
      test_pulse_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
